mips_regfile_write_ctrl: RTL and testbench
==========================================

Name: mips_regfile_write_ctrl

Overview:
- Write-port controller for the 32x32 MIPS register file. It shares the single write port (signal_reg_write / write_reg / write_data) among NUM_REQ requesters using valid/ready handshakes and round-robin arbitration.
- After reset it runs a clear sweep that zeroes all 32 registers before any requester is served.
- It enforces the MIPS rule that writes to register $0 are discarded.

Parameters:
- NUM_REQ, 2, number of write requesters (core writeback, loader/debug, ...).
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, NUM_REQ, per-requester write request.
- req_addr, input, NUM_REQ*ADDR_W, packed register indices; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data, input, NUM_REQ*DATA_W, packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ, one-hot grant; a transfer occurs when req_valid[i] && req_ready[i] at a clk edge.
- signal_reg_write, output, 1, register-file write enable.
- write_reg, output, ADDR_W, register-file write index.
- write_data, output, DATA_W, register-file write data.
- init_busy, output, 1, high while the clear sweep is in progress.

Behaviour:
- States: INIT (clear sweep) and RUN. A 5-bit sweep counter cnt is used in INIT.
- Reset (async, immediate):
  - state=INIT, cnt=0, rr_ptr=0.
  - signal_reg_write=0, write_reg=0, write_data=0, req_ready=0, init_busy=1.
- INIT:
  - Each edge registers signal_reg_write=1, write_reg=cnt, write_data=0, then cnt increments.
  - On the edge that issues cnt=31: state becomes RUN and init_busy falls.
  - The sweep takes exactly 32 edges and does write register 0; the sweep is exempt from the $0 rule.
  - req_ready=0 throughout INIT.
- RUN arbitration (combinational):
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready = onehot(grant) if any valid, else 0.
  - req_ready may depend on req_valid. Requesters must not make valid depend on ready.
  - A requester must hold valid, addr and data stable until it is accepted.
- Transfer at edge t:
  - The transfer registers signal_reg_write, write_reg and write_data, which are visible in cycle t+1. Latency is 1 cycle.
  - rr_ptr becomes (grant+1) mod NUM_REQ.
  - rr_ptr is unchanged on edges with no transfer.
- No transfer at edge t: signal_reg_write=0 in cycle t+1; write_reg and write_data hold their last values.
- $0 rule: a RUN transfer with addr==0 completes its handshake normally, but signal_reg_write stays 0 that cycle.
- Throughput: one accepted write per cycle. Back-to-back writes from the same or different requesters are allowed.
- Fairness: with all requesters continuously valid, grants rotate strictly 0,1,...,NUM_REQ-1.
- Reset mid-sweep or mid-transfer: the pending write is dropped and the sweep restarts at register 0 after release.

Optional Feature:
- Macro: MIPS_REGFILE_INIT_EN.
- Defined: INIT clear sweep as described above.
- Undefined:
  - Reset state is RUN and init_busy is tied 0.
  - req_ready may assert in the first cycle after reset release.
  - No sweep writes are issued.
  - The sweep counter is not instantiated.

Decomposition:
- Package mips_regfile_pkg: state enum {ST_INIT, ST_RUN}, REG_COUNT=32, ZERO_REG=0.
- Sub-module mips_rr_arbiter: holds rr_ptr, takes req_valid and an accept strobe, and produces the one-hot grant. Parameterised by NUM_REQ.
- The top module holds the FSM, the sweep counter, the output registers and the $0 suppression.

Test Plan:
- Clear sweep: release rst and hold both req_valid=1.
  - Expect signal_reg_write=1 with write_reg=0..31 and write_data=0 on 32 consecutive cycles.
  - req_ready must stay 00 throughout.
  - init_busy falls in the cycle write_reg=31 is presented.
- Single write: requester 0 with addr=5, data=0xDEADBEEF, accepted at edge t.
  - Cycle t+1: signal_reg_write=1, write_reg=5, write_data=0xDEADBEEF.
  - Cycle t+2: signal_reg_write=0.
- Contention: both valid continuously with distinct addr/data.
  - Grants alternate 0,1,0,1 and writes appear back-to-back every cycle.
  - Then drop requester 1: requester 0 is granted every cycle.
- $0 discard: requester 1 writes addr=0, data=0x12345678.
  - req_ready[1]=1 and the handshake completes.
  - signal_reg_write stays 0 the next cycle.
- Reset mid-sweep: assert rst when write_reg=10.
  - All outputs go to 0 immediately, without waiting for an edge.
  - After release the sweep restarts at write_reg=0 and completes all 32 writes.
- Macro undefined: release rst with requester 0 valid (addr=7, data=0xA5A5A5A5).
  - req_ready[0]=1 in the first cycle after release.
  - Write appears the following cycle; init_busy stays 0.

Source files
------------

// File: rtl/mips_regfile_pkg.sv
// Shared types and constants for the MIPS register-file write controller.
// Optional build macro: MIPS_REGFILE_INIT_EN (enables the post-reset clear sweep).
package mips_regfile_pkg;

    localparam int          REG_COUNT = 32;
    localparam int unsigned ZERO_REG  = 0;
    localparam int          CNT_W     = $clog2(REG_COUNT);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic logic is_zero_reg(input logic [31:0] idx);
        return idx == 32'(ZERO_REG);
    endfunction

endpackage

// File: rtl/mips_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from rr_ptr.
// rr_ptr advances past the granted requester only on an accepted transfer.
module mips_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;
    int               idx;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PTR_W'(idx);
            end
        end
    end

    assign ptr_nxt = (int'(gnt_idx) == NUM_REQ - 1) ? '0
                   : gnt_idx + PTR_W'(1);

    // Priority pointer moves only when a grant is actually consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mips_regfile_write_ctrl.sv
// Write-port controller for the 32x32 MIPS register file.
// Optional build macro: MIPS_REGFILE_INIT_EN (post-reset clear sweep).
module mips_regfile_write_ctrl
    import mips_regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      signal_reg_write,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic                      init_busy
);

    state_e              state;
    state_e              state_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic                run;
    logic                sweep_done;
    logic [ADDR_W-1:0]   sweep_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

`ifdef MIPS_REGFILE_INIT_EN
    localparam state_e RST_STATE = ST_INIT;

    logic [CNT_W-1:0] cnt;

    // Sweep counter walks every register index once after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sweep_done = (cnt == CNT_W'(REG_COUNT - 1));
    assign sweep_idx  = ADDR_W'(cnt);
    assign init_busy  = (state == ST_INIT);
`else
    localparam state_e RST_STATE = ST_RUN;

    assign sweep_done = 1'b1;
    assign sweep_idx  = '0;
    assign init_busy  = 1'b0;
`endif

    // Requesters are only served in RUN and never while reset is held
    assign run       = (state == ST_RUN) && !rst;
    assign req_ready = run ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    mips_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant)
    );

    // Route the granted requester's index and data to the write port
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave the sweep on the edge that issues the last register index
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT: begin
                if (sweep_done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    // Register-file port: sweep zeroes, else accepted writes minus $0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signal_reg_write <= 1'b0;
            write_reg        <= '0;
            write_data       <= '0;
        end else if (state == ST_INIT) begin
            signal_reg_write <= 1'b1;
            write_reg        <= sweep_idx;
            write_data       <= '0;
        end else begin
            signal_reg_write <= accept && !is_zero_reg(32'(sel_addr));
            if (accept) begin
                write_reg  <= sel_addr;
                write_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile_write_ctrl.sv
// Self-checking bench for mips_regfile_write_ctrl (NUM_REQ=2).
// Covers both builds of MIPS_REGFILE_INIT_EN.
module tb_mips_regfile_write_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        signal_reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        init_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        swe;
        logic        chk;
        logic [4:0]  wr;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[11];

    mips_regfile_write_ctrl #(
        .NUM_REQ (2),
        .DATA_W  (32),
        .ADDR_W  (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .signal_reg_write (signal_reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .init_busy        (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [31:0] d0,
                         input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic check_reset(input logic exp_busy);
        check("rst_swe", 32'(signal_reg_write), 0);
        check("rst_wr", 32'(write_reg), 0);
        check("rst_wd", write_data, 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(init_busy), 32'(exp_busy));
    endtask

    // One RUN cycle: ready before the edge, write port after it
    task automatic cyc(input logic [1:0] e_rdy, input logic e_swe,
                       input logic chk, input logic [4:0] e_wr,
                       input logic [31:0] e_wd, input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        check({tag, "_swe"}, 32'(signal_reg_write), 32'(e_swe));
        if (chk) begin
            check({tag, "_wr"}, 32'(write_reg), 32'(e_wr));
            check({tag, "_wd"}, write_data, e_wd);
        end
        check({tag, "_busy"}, 32'(init_busy), 0);
    endtask

    // Clear sweep starting just after reset release; optional abort
    task automatic sweep(input int stop_at);
        for (int k = 0; k < 32; k++) begin
            check("sweep_ready", 32'(req_ready), 0);
            @(posedge clk);
            #1;
            check("sweep_swe", 32'(signal_reg_write), 1);
            check("sweep_wr", 32'(write_reg), k);
            check("sweep_wd", write_data, 0);
            check("sweep_busy", 32'(init_busy), (k != 31) ? 1 : 0);
            if (k == stop_at) begin
                #1 rst = 1'b1;
                #1;
                check_reset(1'b1);
                return;
            end
        end
    endtask

    initial begin
        bit          mv[2];
        logic [4:0]  ma[2];
        logic [31:0] md[2];
        int          ptr;
        int          g;
        logic [1:0]  e_rdy;
        logic        e_swe;

        tbl[0]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                    2'b00, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5};
        tbl[1]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                    2'b01, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[2]  = '{2'b00, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,
                    2'b00, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[3]  = '{2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222,
                    2'b10, 1'b1, 1'b1, 5'd4, 32'h22222222};
        tbl[4]  = '{2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222,
                    2'b01, 1'b1, 1'b1, 5'd3, 32'h11111111};
        tbl[5]  = '{2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222,
                    2'b10, 1'b1, 1'b1, 5'd4, 32'h22222222};
        tbl[6]  = '{2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222,
                    2'b01, 1'b1, 1'b1, 5'd3, 32'h11111111};
        tbl[7]  = '{2'b01, 5'd3, 5'd4, 32'h11111111, 32'h22222222,
                    2'b01, 1'b1, 1'b1, 5'd3, 32'h11111111};
        tbl[8]  = '{2'b01, 5'd6, 5'd4, 32'h33333333, 32'h22222222,
                    2'b01, 1'b1, 1'b1, 5'd6, 32'h33333333};
        tbl[9]  = '{2'b10, 5'd6, 5'd0, 32'h33333333, 32'h12345678,
                    2'b10, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[10] = '{2'b00, 5'd6, 5'd0, 32'h33333333, 32'h12345678,
                    2'b00, 1'b0, 1'b0, 5'd0, 32'h0};

        rst = 1'b1;
`ifdef MIPS_REGFILE_INIT_EN
        drive(2'b11, 5'd3, 5'd4, 32'h11111111, 32'h22222222);
        #2;
        check_reset(1'b1);
        @(negedge clk) rst = 1'b0;
        sweep(10);
        @(negedge clk) rst = 1'b0;
        sweep(99);
        drive(2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0);
        cyc(2'b01, 1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, "first");
`else
        drive(2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0);
        #2;
        check_reset(1'b0);
        @(posedge clk);
        #1;
        check_reset(1'b0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("first_ready", 32'(req_ready), 32'b01);
        check("first_busy", 32'(init_busy), 0);
        @(posedge clk);
        #1;
        check("first_swe", 32'(signal_reg_write), 1);
        check("first_wr", 32'(write_reg), 7);
        check("first_wd", write_data, 32'hA5A5A5A5);
        check("first_busy2", 32'(init_busy), 0);
`endif

        for (int r = 0; r < 11; r++) begin
            drive(tbl[r].v, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
            cyc(tbl[r].rdy, tbl[r].swe, tbl[r].chk, tbl[r].wr, tbl[r].wd,
                $sformatf("vec%0d", r));
        end

        ptr = 0;
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mv[i]) begin
                    mv[i] = ($urandom_range(0, 3) != 0);
                    ma[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    md[i] = $urandom;
                end
            end
            drive({mv[1], mv[0]}, ma[0], ma[1], md[0], md[1]);
            g = -1;
            for (int k = 0; k < 2; k++) begin
                if (g < 0 && mv[(ptr + k) % 2]) g = (ptr + k) % 2;
            end
            e_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            e_swe = (g >= 0) && (ma[(g >= 0) ? g : 0] != 5'd0);
            cyc(e_rdy, e_swe, e_swe, ma[(g >= 0) ? g : 0],
                md[(g >= 0) ? g : 0], "rand");
            if (g >= 0) begin
                mv[g] = 1'b0;
                ptr = (g + 1) % 2;
            end
        end

        drive(2'b01, 5'd9, 5'd0, 32'h0BADF00D, 32'h0);
        cyc(2'b01, 1'b1, 1'b1, 5'd9, 32'h0BADF00D, "pre_rst");
        drive(2'b11, 5'd12, 5'd13, 32'hCAFE0012, 32'hCAFE0013);
        @(negedge clk);
        check("pre_rst_ready", 32'(req_ready), 32'b10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
`ifdef MIPS_REGFILE_INIT_EN
        check_reset(1'b1);
        @(negedge clk) rst = 1'b0;
        sweep(99);
`else
        check_reset(1'b0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        check("post_rst_swe", 32'(signal_reg_write), 1);
        check("post_rst_wr", 32'(write_reg), 12);
        check("post_rst_wd", write_data, 32'hCAFE0012);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
